// File: rtl/expr_string_tx_if.sv
// expr_string_tx_if: token-in / char-out handshake bundle for expr_string_tx
// master: token producer and char consumer (drives tok_*, out_ready)
// slave : expr_string_tx (drives tok_ready, out_*, busy, err)
interface expr_string_tx_if;
   logic       tok_valid;
   logic       tok_ready;
   logic [3:0] tok_digit;
   logic       tok_op;
   logic       tok_last;
   logic [7:0] out_char;
   logic       out_valid;
   logic       out_ready;
   logic       out_eoe;
   logic       busy;
   logic       err;
   modport master (
      output tok_valid, tok_digit, tok_op, tok_last, out_ready,
      input  tok_ready, out_char, out_valid, out_eoe, busy, err
   );
   modport slave (
      input  tok_valid, tok_digit, tok_op, tok_last, out_ready,
      output tok_ready, out_char, out_valid, out_eoe, busy, err
   );
endinterface

// File: rtl/expr_string_tx.sv
// expr_string_tx: buffers operand/operator tokens and serializes them as ASCII digit (op digit)*
// clk  : clock, all state on posedge
// clr  : synchronous active-high reset
// bus  : token input (tok_*), char output (out_*), busy and sticky err status
module expr_string_tx #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input logic            clk,
   input logic            clr,
   expr_string_tx_if.slave bus
);
   typedef enum logic [1:0] {IDLE, DIGIT, OP} state_t;
   state_t        state_q, state_d;
   logic [5:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          err_q;
   logic [5:0]    head;
   logic          full, empty, acc, push, hs, pop;
   assign head  = mem_q[rd_q];
   assign full  = cnt_q == (AW+1)'(DEPTH);
   assign empty = cnt_q == '0;
   assign bus.tok_ready = !full & !clr;
   assign acc  = bus.tok_valid & bus.tok_ready;
   assign push = acc & (bus.tok_digit <= 4'd9);
   assign hs   = bus.out_valid & bus.out_ready;
   // an entry is only retired once its trailing operator (or final digit) is sent
   assign pop  = hs & ((state_q == OP) | head[5]);
   assign bus.busy = state_q != IDLE;
   assign bus.err  = err_q;
   always_comb begin
      bus.out_valid = state_q == DIGIT ? !empty : state_q == OP;
      bus.out_char  = state_q == OP ? (head[4] ? 8'h2A : 8'h2B) : 8'h30 + {4'd0, head[3:0]};
      bus.out_eoe   = (state_q == DIGIT) & !empty & head[5];
      state_d       = state_q == IDLE  ? (empty ? IDLE : DIGIT) :
                      state_q == DIGIT ? (hs ? (head[5] ? IDLE : OP) : DIGIT) :
                                         (hs ? DIGIT : OP);
   end
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= IDLE;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (push) wr_q <= wr_q + 1'b1;
         if (pop) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
         err_q <= err_q | (acc & (bus.tok_digit > 4'd9));
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= {bus.tok_last, bus.tok_op, bus.tok_digit};
   end
endmodule
